// File: rtl/fib_alu_sequencer.sv
// fib_alu_sequencer
//
// Multi-cycle controller that computes fib(n) mod 2^N. It has no adder or
// comparator of its own. It time-multiplexes an external two-operand ALU:
// ADD produces the next term, and SUB both decrements the loop count and
// tests it for zero through the ALU zero flag.
//
// Optional build macro: FIB_OVF_EN
//   Defined   : ovf is a sticky flag. It is set when the returned term has
//               wrapped past 2^N.
//   Undefined : ovf is tied to 0.
//
// Ports
//   clk, rst                  clock (rising edge); synchronous active-high reset
//   start_valid/start_ready   request handshake; n_in is sampled at acceptance
//   result_valid/result_ready result handshake; result holds fib(n)
//   busy                      high whenever the sequencer is not idle
//   ovf                       sticky wrap flag (FIB_OVF_EN only)
//   alu_a, alu_b, alu_ctrl    operands and opcode driven to the shared ALU
//   alu_result, alu_zero      combinational ALU return path
module fib_alu_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] n_in,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         ovf,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    DEC   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] a, b, cnt, result_q;

  // State register and datapath registers. The spec fixes reset values for
  // the data as well, so everything here is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= {{(N-1){1'b0}}, 1'b1};
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_valid) begin
            cnt <= n_in;
            a   <= '0;
            b   <= {{(N-1){1'b0}}, 1'b1};
          end
        end
        CHECK: begin
          if (alu_zero) result_q <= a;
        end
        ADD: begin
          a <= b;
          b <= alu_result;
        end
        DEC: begin
          cnt <= alu_result;
          // a is not updated in DEC, so it already holds fib(n) here.
          if (alu_zero) result_q <= a;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and ALU operand/opcode decode.
  always_comb begin
    state_nxt = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_ADD;
    case (state)
      IDLE: begin
        if (start_valid) state_nxt = CHECK;
      end
      CHECK: begin
        alu_a     = cnt;
        alu_ctrl  = ALU_SUB;
        state_nxt = alu_zero ? DONE : ADD;
      end
      ADD: begin
        alu_a     = a;
        alu_b     = b;
        state_nxt = DEC;
      end
      DEC: begin
        alu_a     = cnt;
        alu_b     = {{(N-1){1'b0}}, 1'b1};
        alu_ctrl  = ALU_SUB;
        state_nxt = alu_zero ? DONE : ADD;
      end
      DONE: begin
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign result       = result_q;

`ifdef FIB_OVF_EN
  logic b_ovf, ovf_q;

  // An unsigned sum has wrapped exactly when it is smaller than an addend.
  function automatic logic add_wrapped(input logic [N-1:0] sum,
                                       input logic [N-1:0] addend);
    return sum < addend;
  endfunction

  // b_ovf marks that the current b term has wrapped. b moves into a on
  // the same ADD edge, so ovf picks up b_ovf at that point. This keeps ovf
  // in step with whatever a (the eventual result) holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_ovf <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            b_ovf <= 1'b0;
            ovf_q <= 1'b0;
          end
        end
        ADD: begin
          b_ovf <= add_wrapped(alu_result, b);
          ovf_q <= ovf_q | b_ovf;
        end
        default: ;
      endcase
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fib_alu_sequencer.sv
// tb_fib_alu_sequencer
//
// Directed bench for fib_alu_sequencer. It contains a behavioural model of
// the shared ALU. Each request pushes its expected result and ovf value into
// a queue. That entry is popped and compared when result_valid appears.
module tb_fib_alu_sequencer;

  localparam int         N       = 32;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] n_in;
  logic         result_valid;
  logic         result_ready;
  logic [N-1:0] result;
  logic         busy;
  logic         ovf;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic         alu_zero;

  typedef struct {
    logic [N-1:0] r;
    logic         o;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] ctrl_seq[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // ALU model
  assign alu_result = (alu_ctrl == ALU_SUB) ? (alu_a - alu_b) :
                      (alu_ctrl == ALU_ADD) ? (alu_a + alu_b) : '0;
  assign alu_zero   = (alu_result == '0);

  fib_alu_sequencer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .n_in         (n_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy),
    .ovf          (ovf),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // True fib(n) in 64 bits; exact for n <= 93.
  function automatic logic [63:0] fib64(input int n);
    logic [63:0] x, y, t;
    x = 0;
    y = 1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic exp_ovf(input int n);
`ifdef FIB_OVF_EN
    return fib64(n) >= 64'h1_0000_0000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t model(input int n);
    exp_t e;
    logic [63:0] f;
    f   = fib64(n);
    e.r = f[N-1:0];
    e.o = exp_ovf(n);
    return e;
  endfunction

  // Runs one request. The expected entry must already be queued.
  // hold     : cycles to keep result_ready low once DONE is reached
  // pulse_at : cycle (after acceptance) at which a stray start is pulsed; -1 = none
  task automatic run(input int n, input int hold, input int pulse_at);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1);
    start_valid = 1'b1;
    n_in        = N'(n);
    @(negedge clk);
    start_valid = 1'b0;
    n_in        = '0;
    ctrl_seq.delete();
    lat = 0;
    while (!result_valid && lat < 2 * n + 10) begin
      chk("busy_running", busy, 1);
      chk("start_ready_running", start_ready, 0);
      ctrl_seq.push_back(alu_ctrl);
      if (lat == pulse_at) begin
        start_valid = 1'b1;
        n_in        = 3;
      end else begin
        start_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_valid = 1'b0;
    chk("result_valid_seen", result_valid, 1);
    chk("latency", lat, 2 * n + 1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("result", result, e.r);
      chk("ovf", ovf, e.o);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", result_valid, 1);
        chk("hold_result", result, e.r);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("busy_after_ack", busy, 0);
      chk("valid_after_ack", result_valid, 0);
      chk("result_held_idle", result, e.r);
      chk("ovf_held_idle", ovf, e.o);
    end
  endtask

  initial begin
    exp_t e;
    rst          = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    n_in         = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_alu_ctrl", alu_ctrl, ALU_ADD);
    chk("rst_alu_a", alu_a, 0);

    // n=0 takes the CHECK path
    sb.push_back('{r: 32'd0, o: 1'b0});
    run(0, 0, -1);

    // n=1: expect SUB, ADD, SUB
    sb.push_back('{r: 32'd1, o: 1'b0});
    run(1, 0, -1);
    chk("ctrl_seq_len", ctrl_seq.size(), 3);
    if (ctrl_seq.size() == 3) begin
      chk("ctrl0_sub", ctrl_seq[0], ALU_SUB);
      chk("ctrl1_add", ctrl_seq[1], ALU_ADD);
      chk("ctrl2_sub", ctrl_seq[2], ALU_SUB);
    end

    // n=10 with a stray start pulse mid-run
    sb.push_back('{r: 32'd55, o: 1'b0});
    run(10, 0, 5);

    // n=5 with result_ready held low for 6 cycles
    sb.push_back('{r: 32'd5, o: 1'b0});
    run(5, 6, -1);

    // n=20 aborted by reset
    @(negedge clk);
    start_valid = 1'b1;
    n_in        = 20;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result_valid", result_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_start_ready", start_ready, 1);
    chk("abort_alu_a", alu_a, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_valid", result_valid, 0);

    sb.push_back('{r: 32'd2, o: 1'b0});
    run(3, 0, -1);

    // small sweep against the model
    for (int k = 2; k <= 8; k++) begin
      sb.push_back(model(k));
      run(k, 1, -1);
    end

    // wrap boundary
`ifdef FIB_OVF_EN
    sb.push_back('{r: 32'd2971215073, o: 1'b0});
    run(47, 0, -1);
    sb.push_back('{r: 32'd512559680, o: 1'b1});
    run(48, 0, -1);
`else
    sb.push_back('{r: 32'd2971215073, o: 1'b0});
    run(47, 0, -1);
    sb.push_back('{r: 32'd512559680, o: 1'b0});
    run(48, 0, -1);
`endif

    // ovf clears on the next acceptance
    sb.push_back('{r: 32'd13, o: 1'b0});
    run(7, 0, -1);

    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
